// File: rtl/demux8_deser.sv
// Serial-to-parallel slot demux: rebuilds an 8-bit slot word from one bit per handshake.
// Optional `PARITY_EN adds a 9th even-parity beat per word and drives err on mismatch.
module demux8_deser #(
    parameter int unsigned     NSLOT = 8,
    parameter logic [NSLOT-1:0] RST_W = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             din,
    input  logic             din_vld,
    output logic             din_rdy,
    input  logic             din_frm,
    output logic [NSLOT-1:0] dout,
    output logic             dout_vld,
    input  logic             dout_rdy,
    output logic [2:0]       slot,
    output logic             drop,
    output logic             err
);

    localparam logic [2:0] LastSlot = 3'(NSLOT - 1);

    logic [2:0]       slot_q, slot_d;
    logic [NSLOT-1:0] acc_q, acc_d;
    logic [NSLOT-1:0] dout_q, dout_d;
    logic             dout_vld_q, dout_vld_d;
    logic             drop_q, drop_d;

    logic             din_xfer;
    logic             dout_xfer;
    logic             last_beat;
    logic             partial;
    logic [NSLOT-1:0] acc_ins;

`ifdef PARITY_EN
    logic par_phase_q, par_phase_d;
    logic err_q, err_d;

    // The parity beat is the one that loads dout, so it carries the stall rule.
    assign last_beat = par_phase_q;
    assign partial   = (slot_q != 3'd0) | par_phase_q;
`else
    assign last_beat = (slot_q == LastSlot);
    assign partial   = (slot_q != 3'd0);
`endif

    assign din_rdy   = ~last_beat | ~dout_vld_q | dout_rdy;
    assign din_xfer  = din_vld & din_rdy;
    assign dout_xfer = dout_vld_q & dout_rdy;

    always_comb begin
        acc_ins         = acc_q;
        acc_ins[slot_q] = din;
    end

    always_comb begin
        slot_d     = slot_q;
        acc_d      = acc_q;
        dout_d     = dout_q;
        dout_vld_d = dout_vld_q;
        drop_d     = 1'b0;
`ifdef PARITY_EN
        par_phase_d = par_phase_q;
        err_d       = 1'b0;
`endif

        if (dout_xfer) begin
            dout_vld_d = 1'b0;
        end

        if (din_xfer) begin
            if (din_frm) begin
                // Realign: this bit is slot 0 of a fresh word, any partial word is lost.
                acc_d  = {{(NSLOT-1){1'b0}}, din};
                slot_d = 3'd1;
                drop_d = partial;
`ifdef PARITY_EN
                par_phase_d = 1'b0;
`endif
            end else if (last_beat) begin
                acc_d      = '0;
                dout_vld_d = 1'b1;
`ifdef PARITY_EN
                dout_d      = acc_q;
                err_d       = (^acc_q) ^ din;
                par_phase_d = 1'b0;
`else
                dout_d = acc_ins;
                slot_d = 3'd0;
`endif
            end else begin
                acc_d  = acc_ins;
                slot_d = slot_q + 3'd1;
`ifdef PARITY_EN
                par_phase_d = (slot_q == LastSlot);
`endif
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            slot_q     <= 3'd0;
            acc_q      <= '0;
            dout_q     <= RST_W;
            dout_vld_q <= 1'b0;
            drop_q     <= 1'b0;
        end else begin
            slot_q     <= slot_d;
            acc_q      <= acc_d;
            dout_q     <= dout_d;
            dout_vld_q <= dout_vld_d;
            drop_q     <= drop_d;
        end
    end

`ifdef PARITY_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            par_phase_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            par_phase_q <= par_phase_d;
            err_q       <= err_d;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    assign dout     = dout_q;
    assign dout_vld = dout_vld_q;
    assign slot     = slot_q;
    assign drop     = drop_q;

    // A stalled output word must not move until the consumer takes it.
    hold_stable_a : assert property (@(posedge clk) disable iff (rst)
        (dout_vld_q && !dout_rdy) |=> (dout_vld_q && $stable(dout_q)));

endmodule

// File: tb/tb_demux8_deser.sv
// Bench for demux8_deser: behavioural model + scoreboard queue of expected words,
// directed cases followed by 1000 randomly gapped words. Honours `PARITY_EN.
module tb_demux8_deser;

    localparam logic [7:0] RST_W = 8'h5A;
`ifdef PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif

    logic       clk;
    logic       rst;
    logic       din;
    logic       din_vld;
    logic       din_rdy;
    logic       din_frm;
    logic [7:0] dout;
    logic       dout_vld;
    logic       dout_rdy;
    logic [2:0] slot;
    logic       drop;
    logic       err;

    demux8_deser #(
        .NSLOT (8),
        .RST_W (RST_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .din      (din),
        .din_vld  (din_vld),
        .din_rdy  (din_rdy),
        .din_frm  (din_frm),
        .dout     (dout),
        .dout_vld (dout_vld),
        .dout_rdy (dout_rdy),
        .slot     (slot),
        .drop     (drop),
        .err      (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model state, advanced once per cycle from the pre-edge inputs.
    logic [2:0] m_slot;
    logic [7:0] m_acc;
    logic [7:0] m_dout;
    logic       m_vld;
    logic       m_drop;
    logic       m_err;
    logic       m_par;
    logic [7:0] sb[$];
    logic       m_last, m_rdy, m_in, m_out;
    logic [7:0] m_w;
    int         drop_cnt = 0;
    int         err_cnt  = 0;
    int         out_cnt  = 0;
    logic [7:0] last_out = 8'h00;
    bit         rnd      = 1'b0;

    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                m_slot = 3'd0;
                m_acc  = 8'h00;
                m_dout = RST_W;
                m_vld  = 1'b0;
                m_drop = 1'b0;
                m_err  = 1'b0;
                m_par  = 1'b0;
                sb.delete();
            end else begin
                m_last = PAR ? m_par : (m_slot == 3'd7);
                m_rdy  = !m_last || !m_vld || dout_rdy;
                check_eq("din_rdy", din_rdy, m_rdy);
                check_eq("dout_vld", dout_vld, m_vld);
                check_eq("slot", slot, m_slot);
                check_eq("dout", dout, m_dout);
                check_eq("drop", drop, m_drop);
                check_eq("err", err, m_err);
                if (drop) drop_cnt++;
                if (err) err_cnt++;

                m_in   = din_vld && m_rdy;
                m_out  = m_vld && dout_rdy;
                m_drop = 1'b0;
                m_err  = 1'b0;
                if (m_out) begin
                    if (sb.size() == 0) begin
                        check_eq("sb_nonempty", sb.size(), 1);
                    end else begin
                        m_w = sb.pop_front();
                        check_eq("word_order", dout, m_w);
                        last_out = dout;
                        out_cnt++;
                    end
                    m_vld = 1'b0;
                end
                if (m_in) begin
                    if (din_frm) begin
                        m_drop = (m_slot != 3'd0) || m_par;
                        m_acc  = {7'b0, din};
                        m_slot = 3'd1;
                        m_par  = 1'b0;
                    end else if (PAR && m_par) begin
                        sb.push_back(m_acc);
                        m_dout = m_acc;
                        m_vld  = 1'b1;
                        m_err  = ((^m_acc) != din);
                        m_acc  = 8'h00;
                        m_par  = 1'b0;
                    end else begin
                        m_acc[m_slot] = din;
                        if (m_slot == 3'd7) begin
                            if (PAR) begin
                                m_par = 1'b1;
                            end else begin
                                sb.push_back(m_acc);
                                m_dout = m_acc;
                                m_vld  = 1'b1;
                                m_acc  = 8'h00;
                            end
                        end
                        m_slot = 3'(m_slot + 3'd1);
                    end
                end
            end
        end
    end

    // Random consumer back-pressure during the soak phase.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rnd) dout_rdy = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Present one bit and hold it until the block accepts it.
    task automatic beat(input logic b, input logic f);
        logic got;
        got     = 1'b0;
        din     = b;
        din_frm = f;
        din_vld = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            got = din_rdy;
            @(posedge clk);
            #1;
            if (got) break;
        end
        if (!got) check_eq("beat_accept", got, 1);
        din_vld = 1'b0;
        din_frm = 1'b0;
    endtask

    task automatic send_bits(input logic [7:0] w, input int n);
        for (int i = 0; i < n; i++) beat(w[i], 1'b0);
    endtask

    task automatic send_word(input logic [7:0] w);
        send_bits(w, 8);
        if (PAR) beat(^w, 1'b0);
    endtask

    int         base;
    logic [7:0] w;
    logic       f;

    initial begin
        rst      = 1'b1;
        din      = 1'b0;
        din_vld  = 1'b0;
        din_frm  = 1'b0;
        dout_rdy = 1'b0;
        cycles(3);
        rst = 1'b0;
        @(negedge clk);
        check_eq("rst_dout", dout, RST_W);
        check_eq("rst_vld", dout_vld, 0);
        check_eq("rst_rdy", din_rdy, 1);
        check_eq("rst_slot", slot, 0);
        @(posedge clk);
        #1;

        // Single word, consumer always ready.
        dout_rdy = 1'b1;
        send_word(8'h4D);
        cycles(3);
        check_eq("t1_word", last_out, 8'h4D);
        check_eq("t1_count", out_cnt, 1);

        // Second word's completing beat stalls behind an untaken first word.
        dout_rdy = 1'b0;
        base     = out_cnt;
        send_word(8'hFF);
        send_bits(8'h00, PAR ? 8 : 7);
        din     = 1'b0;
        din_vld = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check_eq("t2_stall_rdy", din_rdy, 0);
        end
        @(posedge clk);
        #1;
        dout_rdy = 1'b1;
        beat(1'b0, 1'b0);
        cycles(3);
        check_eq("t2_count", out_cnt - base, 2);
        check_eq("t2_last", last_out, 8'h00);

        // Realign after three bits.
        base = drop_cnt;
        send_bits(8'h05, 3);
        beat(1'b1, 1'b1);
        for (int i = 1; i < 8; i++) beat(1'b1, 1'b0);
        if (PAR) beat(1'b0, 1'b0);
        cycles(3);
        check_eq("t3_drop", drop_cnt - base, 1);
        check_eq("t3_word", last_out, 8'hFF);
        @(negedge clk);
        check_eq("t3_slot", slot, 0);
        @(posedge clk);
        #1;

        // Reset mid-word, then with a word pending.
        send_bits(8'hFF, 5);
        rst = 1'b1;
        cycles(1);
        rst = 1'b0;
        @(negedge clk);
        check_eq("t4a_slot", slot, 0);
        check_eq("t4a_vld", dout_vld, 0);
        check_eq("t4a_dout", dout, RST_W);
        @(posedge clk);
        #1;
        dout_rdy = 1'b0;
        send_word(8'hA5);
        cycles(1);
        rst = 1'b1;
        cycles(1);
        rst = 1'b0;
        @(negedge clk);
        check_eq("t4b_vld", dout_vld, 0);
        check_eq("t4b_dout", dout, RST_W);
        @(posedge clk);
        #1;
        dout_rdy = 1'b1;
        base     = out_cnt;
        send_word(8'h3C);
        cycles(3);
        check_eq("t4_clean", last_out, 8'h3C);
        check_eq("t4_count", out_cnt - base, 1);

`ifdef PARITY_EN
        base = err_cnt;
        send_bits(8'h01, 8);
        beat(1'b0, 1'b0);
        cycles(3);
        check_eq("par_bad_err", err_cnt - base, 1);
        check_eq("par_bad_word", last_out, 8'h01);
        send_bits(8'h01, 8);
        beat(1'b1, 1'b0);
        cycles(3);
        check_eq("par_good_err", err_cnt - base, 1);
        check_eq("par_good_word", last_out, 8'h01);
`endif

        // Soak: random source gaps, sink stalls and occasional realigns.
        base = out_cnt;
        rnd  = 1'b1;
        for (int n = 0; n < 1000; n++) begin
            w = 8'($urandom);
            f = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 49) == 0) begin
                send_bits(8'($urandom), int'($urandom_range(1, 6)));
                f = 1'b1;
            end
            for (int i = 0; i < 8; i++) begin
                if ($urandom_range(0, 3) == 0) cycles(1);
                beat(w[i], (i == 0) ? f : 1'b0);
            end
            if (PAR) beat((^w) ^ ($urandom_range(0, 15) == 0), 1'b0);
        end
        rnd      = 1'b0;
        dout_rdy = 1'b1;
        cycles(5);
        check_eq("soak_words", out_cnt - base, 1000);
        check_eq("soak_drain", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
